// File: rtl/pipe_addsub_pkg.sv
// Shared constants, stage-count helper and stage payload layout for pipe_addsub.
package pipe_addsub_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CHUNK = 8;

  function automatic int calc_stages(input int width, input int chunk);
    return (chunk > 0) ? width / chunk : 0;
  endfunction

  // Payload carried by each stage register at the default width.
  typedef struct packed {
    logic                 vld;
    logic                 cy;
    logic                 sub;
    logic [DEF_WIDTH-1:0] sum;
    logic [DEF_WIDTH-1:0] a;
    logic [DEF_WIDTH-1:0] b;
  } stage_pl_t;

endpackage

// File: rtl/pipe_addsub_if.sv
// Operand/result handshake bundle; slave is the adder side, master the producer/consumer side.
interface pipe_addsub_if
  import pipe_addsub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport slave (
    input  in_valid, in_a, in_b, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport master (
    output in_valid, in_a, in_b, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/pipe_addsub_slice.sv
// CHUNK-bit combinational ripple adder; also reports the carry into its MSB for overflow detection.
module pipe_addsub_slice #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_cmsb,
  output logic             o_cout
);
  logic w_c;

  always_comb begin
    w_c    = i_cin;
    o_sum  = '0;
    o_cmsb = 1'b0;
    for (int k = 0; k < CHUNK; k++) begin
      if (k == CHUNK - 1) o_cmsb = w_c;
      o_sum[k] = i_a[k] ^ i_b[k] ^ w_c;
      w_c      = (i_a[k] & i_b[k]) | (w_c & (i_a[k] ^ i_b[k]));
    end
    o_cout = w_c;
  end
endmodule

// File: rtl/pipe_addsub.sv
// Pipelined add/sub, one CHUNK-bit carry slice per stage, STAGES-edge latency, valid/ready both sides.
// Stalls propagate back to in_ready combinationally; define PIPE_ADDSUB_SAT_EN to clamp on signed overflow.
module pipe_addsub
  import pipe_addsub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input logic          clk,
  input logic          rst_n,
  pipe_addsub_if.slave bus
);
  localparam int STAGES = calc_stages(WIDTH, CHUNK);

  if (CHUNK < 1 || WIDTH < CHUNK || (WIDTH % CHUNK) != 0) begin : g_cfg_check
    $error("pipe_addsub: WIDTH (%0d) must be a nonzero multiple of CHUNK (%0d)", WIDTH, CHUNK);
  end

  // Same layout as stage_pl_t, sized by this instance's WIDTH.
  typedef struct packed {
    logic             vld;
    logic             cy;
    logic             sub;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } pl_t;

  pl_t               r_st     [STAGES];
  logic              r_ovf;
  pl_t               w_src    [STAGES];
  pl_t               w_nxt    [STAGES];
  logic [CHUNK-1:0]  w_sum_ch [STAGES];
  logic              w_cmsb   [STAGES];
  logic              w_cout   [STAGES];
  logic [STAGES-1:0] w_load;
  logic              w_room;
  logic              w_ovf;

  // B is inverted chunk by chunk as it reaches its stage, using the sub bit that travels with it.
  for (genvar i = 0; i < STAGES; i++) begin : g_slice
    pipe_addsub_slice #(.CHUNK(CHUNK)) u_slice (
      .i_a    (w_src[i].a[i*CHUNK +: CHUNK]),
      .i_b    (w_src[i].b[i*CHUNK +: CHUNK] ^ {CHUNK{w_src[i].sub}}),
      .i_cin  (w_src[i].cy),
      .o_sum  (w_sum_ch[i]),
      .o_cmsb (w_cmsb[i]),
      .o_cout (w_cout[i])
    );
  end

  always_comb begin
    w_src[0]     = '0;
    w_src[0].vld = bus.in_valid;
    w_src[0].cy  = bus.in_sub;
    w_src[0].sub = bus.in_sub;
    w_src[0].a   = bus.in_a;
    w_src[0].b   = bus.in_b;
    for (int i = 1; i < STAGES; i++) w_src[i] = r_st[i-1];
  end

  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      w_nxt[i]                       = w_src[i];
      w_nxt[i].cy                    = w_cout[i];
      w_nxt[i].sum[i*CHUNK +: CHUNK] = w_sum_ch[i];
    end
    w_ovf = w_cmsb[STAGES-1] ^ w_cout[STAGES-1];
`ifdef PIPE_ADDSUB_SAT_EN
    if (w_ovf) begin
      w_nxt[STAGES-1].sum = {w_src[STAGES-1].a[WIDTH-1], {(WIDTH-1){~w_src[STAGES-1].a[WIDTH-1]}}};
    end
`endif
  end

  // A stage may load when it, or any stage downstream of it, is empty, or the consumer takes a result.
  always_comb begin
    w_room = bus.out_ready;
    w_load = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      w_room    = w_room || !r_st[i].vld;
      w_load[i] = w_room;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) r_st[i] <= '0;
      r_ovf <= 1'b0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (w_load[i]) begin
          if (w_src[i].vld) r_st[i]     <= w_nxt[i];
          else              r_st[i].vld <= 1'b0;
        end
      end
      if (w_load[STAGES-1] && w_src[STAGES-1].vld) r_ovf <= w_ovf;
    end
  end

  assign bus.in_ready  = w_load[0];
  assign bus.out_valid = r_st[STAGES-1].vld;
  assign bus.out_sum   = r_st[STAGES-1].sum;
  assign bus.out_cout  = r_st[STAGES-1].cy;
  assign bus.out_ovf   = r_ovf;
endmodule
